// File: rtl/mem_access32.sv
// Memory/IO access stage: decodes the effective address into data RAM, the IO
// window or unmapped space, and stalls the core until load data or an error is ready.
//
// state   | meaning
// IDLE    | decode request; RAM stores and faults complete here
// RAM_RD  | RAM read data returning, captured into rdata_q
// IO_WAIT | IO strobe held, waiting for io_ready or timeout
// DONE    | present rdata_q/err_q to writeback, release stall
module mem_access32 #(
    parameter int RAM_AW     = 14,
    parameter int IO_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Mem_read,
    input  logic              Mem_write,
    input  logic [31:0]       ALU_Result,
    input  logic [31:0]       Read_data_2,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              io_rd,
    output logic              io_wr,
    output logic [9:0]        io_addr,
    output logic [31:0]       io_wdata,
    input  logic [31:0]       io_rdata,
    input  logic              io_ready,
    output logic              Mem_stall,
    output logic [31:0]       Read_data,
    output logic              Bus_err,
    output logic              Err_status
);

    localparam int         RAM_HI  = RAM_AW + 2;
    localparam logic [7:0] TO_LAST = 8'(IO_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RAM_RD  = 2'd1,
        S_IO_WAIT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_rdata_q;
    logic        r_err_q;
    logic [7:0]  r_count;
    logic        r_err_status;

    logic w_req;
    logic w_in_ram;
    logic w_in_io;
    logic w_fault;
    logic w_ok;
    logic w_timeout;

    assign w_req     = Mem_read | Mem_write;
    assign w_in_ram  = (ALU_Result[31:RAM_HI] == '0);
    assign w_in_io   = (ALU_Result[31:10] == 22'h3FFFFF);
    assign w_fault   = w_req & ((~w_in_ram & ~w_in_io)
                              | (ALU_Result[1:0] != 2'b00)
                              | (Mem_read & Mem_write));
    assign w_ok      = w_req & ~w_fault;
    assign w_timeout = (r_count == TO_LAST) & ~io_ready;

    assign ram_addr   = ALU_Result[RAM_HI-1:2];
    assign ram_wdata  = Read_data_2;
    assign io_addr    = ALU_Result[9:0];
    assign io_wdata   = Read_data_2;
    assign Err_status = r_err_status;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_rdata_q    <= '0;
            r_err_q      <= 1'b0;
            r_count      <= '0;
            r_err_status <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_fault)
                        r_err_status <= 1'b1;
                    if (w_ok && w_in_io)
                        r_count <= '0;
                end
                S_RAM_RD: r_rdata_q <= ram_rdata;
                S_IO_WAIT: begin
                    // ready on the last allowed cycle still counts as success
                    if (io_ready) begin
                        if (Mem_read)
                            r_rdata_q <= io_rdata;
                    end else if (r_count == TO_LAST) begin
                        r_rdata_q <= '0;
                        r_err_q   <= 1'b1;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                S_DONE: begin
                    if (r_err_q)
                        r_err_status <= 1'b1;
                    r_err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        io_rd     = 1'b0;
        io_wr     = 1'b0;
        Mem_stall = 1'b0;
        Read_data = '0;
        Bus_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fault) begin
                    Bus_err = 1'b1;
                end else if (w_ok && w_in_ram) begin
                    if (Mem_write) begin
                        ram_we = 1'b1;
                    end else begin
                        ram_en    = 1'b1;
                        Mem_stall = 1'b1;
                        w_next    = S_RAM_RD;
                    end
                end else if (w_ok && w_in_io) begin
                    io_rd     = Mem_read;
                    io_wr     = Mem_write;
                    Mem_stall = 1'b1;
                    w_next    = S_IO_WAIT;
                end
            end
            S_RAM_RD: begin
                Mem_stall = 1'b1;
                w_next    = S_DONE;
            end
            S_IO_WAIT: begin
                Mem_stall = 1'b1;
                io_rd     = Mem_read;
                io_wr     = Mem_write;
                if (io_ready || w_timeout)
                    w_next = S_DONE;
            end
            S_DONE: begin
                Read_data = r_rdata_q;
                Bus_err   = r_err_q;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // strobes drop with reset even while the held request is still present
        if (!reset) begin
            ram_en    = 1'b0;
            ram_we    = 1'b0;
            io_rd     = 1'b0;
            io_wr     = 1'b0;
            Mem_stall = 1'b0;
            Bus_err   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access32.sv
// Directed bench for mem_access32: RAM store/load, IO read/write, timeout,
// faults and reset during an IO access.
module tb_mem_access32;

    logic        clock = 1'b0;
    logic        reset;
    logic        Mem_read, Mem_write;
    logic [31:0] ALU_Result, Read_data_2;
    logic        ram_en, ram_we;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        io_rd, io_wr;
    logic [9:0]  io_addr;
    logic [31:0] io_wdata, io_rdata;
    logic        io_ready;
    logic        Mem_stall;
    logic [31:0] Read_data;
    logic        Bus_err, Err_status;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:16383];

    mem_access32 #(.RAM_AW(14), .IO_TIMEOUT(15)) dut (
        .clock(clock), .reset(reset),
        .Mem_read(Mem_read), .Mem_write(Mem_write),
        .ALU_Result(ALU_Result), .Read_data_2(Read_data_2),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ready(io_ready),
        .Mem_stall(Mem_stall), .Read_data(Read_data),
        .Bus_err(Bus_err), .Err_status(Err_status)
    );

    always #5 clock = ~clock;

    // synchronous RAM model
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_en) ram_rdata <= mem[ram_addr];
    end

    // Runs one IO access; ready_c is the cycle index (0 = IDLE cycle) io_ready is high, -1 for never.
    task automatic run_io(input bit rd, input logic [31:0] addr, input int ready_c,
                          output int strobe_cnt, output int stall_cnt, output int occ,
                          output logic [31:0] rdat, output logic berr,
                          output logic [9:0] addr_seen, output bit done);
        int c;
        c = 0; strobe_cnt = 0; stall_cnt = 0; occ = 0; rdat = '0; berr = 1'b0; done = 0;
        addr_seen = '0;
        Mem_read = rd; Mem_write = !rd; ALU_Result = addr; Read_data_2 = 32'hA5A5_0F0F;
        io_ready = (ready_c == 0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (c == 0) addr_seen = io_addr;
            if (rd ? io_rd : io_wr) strobe_cnt++;
            if (Mem_stall) stall_cnt++;
            else begin
                done = 1; rdat = Read_data; berr = Bus_err; occ = c + 1;
                break;
            end
            @(posedge clock); #1;
            c++;
            io_ready = (c == ready_c);
        end
        @(posedge clock); #1;
        Mem_read = 0; Mem_write = 0; io_ready = 0;
    endtask

    task automatic test_reset;
        reset = 0; Mem_read = 0; Mem_write = 0; ALU_Result = '0; Read_data_2 = '0;
        io_rdata = '0; io_ready = 0;
        #3;
        checks++;
        if ({ram_en, ram_we, io_rd, io_wr, Mem_stall, Bus_err, Err_status} !== 7'b0 || Read_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: got strobes/flags=%b Read_data=%h, want all 0",
                     {ram_en, ram_we, io_rd, io_wr, Mem_stall, Bus_err, Err_status}, Read_data);
        end
        @(negedge clock); reset = 1;
        @(posedge clock); #1;
        checks++;
        if (Mem_stall !== 1'b0 || Read_data !== 32'h0 || Err_status !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: stall=%b rd=%h err=%b, want 0", Mem_stall, Read_data, Err_status);
        end
    endtask

    task automatic test_ram_store_load;
        Mem_write = 1; ALU_Result = 32'h0000_0040; Read_data_2 = 32'hCAFE_BABE;
        @(negedge clock);
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== 14'h010 || Mem_stall !== 1'b0 || ram_en !== 1'b0) begin
            failures++;
            $display("FAIL ram_store: we=%b addr=%h stall=%b en=%b, want 1/010/0/0", ram_we, ram_addr, Mem_stall, ram_en);
        end
        @(posedge clock); #1;
        Mem_write = 0; Mem_read = 1; Read_data_2 = '0;
        @(negedge clock);
        checks++;
        if (ram_we !== 1'b0 || ram_en !== 1'b1 || Mem_stall !== 1'b1 || Read_data !== 32'h0) begin
            failures++;
            $display("FAIL ram_load_c0: we=%b en=%b stall=%b rd=%h, want 0/1/1/0", ram_we, ram_en, Mem_stall, Read_data);
        end
        @(posedge clock); #1;
        @(negedge clock);
        checks++;
        if (Mem_stall !== 1'b1 || ram_en !== 1'b0) begin
            failures++;
            $display("FAIL ram_load_c1: stall=%b en=%b, want 1/0", Mem_stall, ram_en);
        end
        @(posedge clock); #1;
        @(negedge clock);
        checks++;
        if (Mem_stall !== 1'b0 || Read_data !== 32'hCAFE_BABE || Bus_err !== 1'b0) begin
            failures++;
            $display("FAIL ram_load_done: stall=%b rd=%h berr=%b, want 0/cafebabe/0", Mem_stall, Read_data, Bus_err);
        end
        @(posedge clock); #1;
        Mem_read = 0;
        @(negedge clock);
        checks++;
        if (Read_data !== 32'h0 || Mem_stall !== 1'b0) begin
            failures++;
            $display("FAIL ram_load_after: rd=%h stall=%b, want 0/0", Read_data, Mem_stall);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_io_read;
        int sc, st, oc; logic [31:0] rd; logic be; logic [9:0] ad; bit dn;
        io_rdata = 32'h1234_5678;
        run_io(1'b1, 32'hFFFF_FC60, 3, sc, st, oc, rd, be, ad, dn);
        checks++;
        if (dn !== 1'b1 || sc != 4 || st != 4 || oc != 5) begin
            failures++;
            $display("FAIL io_read_timing: done=%b io_rd=%0d stall=%0d occ=%0d, want 1/4/4/5", dn, sc, st, oc);
        end
        checks++;
        if (rd !== 32'h1234_5678 || be !== 1'b0 || ad !== 10'h060) begin
            failures++;
            $display("FAIL io_read_data: rd=%h berr=%b addr=%h, want 12345678/0/060", rd, be, ad);
        end
    endtask

    task automatic test_io_ready_at_timeout;
        int sc, st, oc; logic [31:0] rd; logic be; logic [9:0] ad; bit dn;
        io_rdata = 32'h0BAD_F00D;
        run_io(1'b1, 32'hFFFF_FFFC, 15, sc, st, oc, rd, be, ad, dn);
        checks++;
        if (dn !== 1'b1 || sc != 16 || oc != 17 || rd !== 32'h0BAD_F00D || be !== 1'b0 || Err_status !== 1'b0) begin
            failures++;
            $display("FAIL io_ready_wins: done=%b io_rd=%0d occ=%0d rd=%h berr=%b sticky=%b, want 1/16/17/0badf00d/0/0",
                     dn, sc, oc, rd, be, Err_status);
        end
    endtask

    task automatic test_io_timeout;
        int sc, st, oc; logic [31:0] rd; logic be; logic [9:0] ad; bit dn;
        io_rdata = 32'hFFFF_FFFF;
        run_io(1'b0, 32'hFFFF_FC10, -1, sc, st, oc, rd, be, ad, dn);
        checks++;
        if (dn !== 1'b1 || sc != 16 || st != 16 || oc != 17) begin
            failures++;
            $display("FAIL io_timeout_timing: done=%b io_wr=%0d stall=%0d occ=%0d, want 1/16/16/17", dn, sc, st, oc);
        end
        checks++;
        if (rd !== 32'h0 || be !== 1'b1 || Err_status !== 1'b1) begin
            failures++;
            $display("FAIL io_timeout_err: rd=%h berr=%b sticky=%b, want 0/1/1", rd, be, Err_status);
        end
        @(negedge clock);
        checks++;
        if (Bus_err !== 1'b0) begin
            failures++;
            $display("FAIL io_timeout_pulse: berr=%b one cycle later, want 0", Bus_err);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_faults;
        logic [31:0] addrs [3];
        addrs[0] = 32'h0001_0000; addrs[1] = 32'h0000_0042; addrs[2] = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            Mem_read = 1; Mem_write = (i == 2); ALU_Result = addrs[i];
            @(negedge clock);
            checks++;
            if ({ram_en, ram_we, io_rd, io_wr, Mem_stall} !== 5'b0 || Bus_err !== 1'b1 || Read_data !== 32'h0) begin
                failures++;
                $display("FAIL fault_%0d: strobes/stall=%b berr=%b rd=%h, want 00000/1/0",
                         i, {ram_en, ram_we, io_rd, io_wr, Mem_stall}, Bus_err, Read_data);
            end
            @(posedge clock); #1;
        end
        Mem_read = 0; Mem_write = 0; ALU_Result = '0;
        @(negedge clock);
        checks++;
        if (Bus_err !== 1'b0 || Mem_stall !== 1'b0) begin
            failures++;
            $display("FAIL fault_clear: berr=%b stall=%b, want 0/0", Bus_err, Mem_stall);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid_io;
        Mem_read = 1; ALU_Result = 32'hFFFF_FC00; io_ready = 0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(negedge clock);
        checks++;
        if (io_rd !== 1'b1 || Mem_stall !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre: io_rd=%b stall=%b, want 1/1", io_rd, Mem_stall);
        end
        #2 reset = 0;
        #1;
        checks++;
        if (io_rd !== 1'b0 || Mem_stall !== 1'b0 || Err_status !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_drop: io_rd=%b stall=%b sticky=%b, want 0/0/0", io_rd, Mem_stall, Err_status);
        end
        Mem_read = 0; ALU_Result = '0; Read_data_2 = '0;
        @(posedge clock); #1;
        reset = 1;
        @(negedge clock);
        checks++;
        if ({ram_en, ram_we, io_rd, io_wr, Mem_stall, Bus_err, Err_status} !== 7'b0 ||
            Read_data !== 32'h0 || ram_addr !== 14'h0 || io_addr !== 10'h0 ||
            ram_wdata !== 32'h0 || io_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_idle: flags=%b rd=%h, want all 0",
                     {ram_en, ram_we, io_rd, io_wr, Mem_stall, Bus_err, Err_status}, Read_data);
        end
        @(posedge clock); #1;
        Mem_write = 1; ALU_Result = 32'h0000_0004; Read_data_2 = 32'h1;
        @(negedge clock);
        checks++;
        if (ram_we !== 1'b1 || Mem_stall !== 1'b0 || ram_addr !== 14'h001) begin
            failures++;
            $display("FAIL reset_mid_state: we=%b stall=%b addr=%h, want 1/0/001 (IDLE)", ram_we, Mem_stall, ram_addr);
        end
        @(posedge clock); #1;
        Mem_write = 0;
    endtask

    initial begin
        test_reset();
        test_ram_store_load();
        test_io_read();
        test_io_ready_at_timeout();
        test_io_timeout();
        test_faults();
        test_reset_mid_io();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
